hpdmc_databridge: RTL
=====================

Name: hpdmc_databridge

Overview:
Host-side burst sequencer for the DDR datapath buffers. It accepts 4-beat × 64-bit write bursts and read-burst requests from the bus interface. For writes it fills the datapath write buffer and drives op_write. For reads it drives op_read, then drains the datapath read buffer. It sits between the bus port and the DDR I/O datapath, and is paced by the SDRAM command scheduler through go/done strobes.

Parameters:
RD_LAT, 4, clk cycles from the end of op_read to the first read-buffer pop; legal range 1..15.
WCNT_W, 16, width of the optional statistics counters.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  reset, asynchronous, active-high.
wr_req  in  1  host presents a write beat.
wr_ack  out  1  beat accepted this cycle.
wr_dat  in  64  write beat data.
wr_mask  in  8  write beat byte mask; 1 = byte not written.
rd_req  in  1  host requests one read burst; level, held until rd_ack.
rd_ack  out  1  read request accepted (1-cycle pulse).
rd_dat  out  64  read beat data.
rd_valid  out  1  rd_dat valid; exactly 4 consecutive pulses per burst.
wgo  in  1  scheduler: write command issued, start data phase.
rgo  in  1  scheduler: read command issued, start data phase.
wready  out  1  write buffer holds a full burst; scheduler may issue WRITE.
busy  out  1  FSM not in IDLE.
op_write  out  1  to datapath; high exactly 4 cycles per write burst.
op_read  out  1  to datapath; high exactly 4 cycles per read burst.
buffer_w_next  out  1  push one beat into the write buffer.
buffer_w_nextburst  out  1  reset the write-buffer pointer and set all masks to 1.
buffer_w_mask  out  8  beat mask to the write buffer (= wr_mask).
buffer_w_dat  out  64  beat data to the write buffer (= wr_dat).
buffer_r_next  out  1  advance the read-buffer pointer.
buffer_r_nextburst  out  1  reset the read-buffer pointer to 0.
buffer_r_dat  in  64  read-buffer output at the current pointer (combinational).

Behaviour:
- Reset: FSM=IDLE, beat counter=0, latency counter=0. All outputs 0, including rd_dat=0.
- States and transitions:
  - IDLE:
    - If wr_req: go to WCLR. Write has priority when wr_req and rd_req are both high.
    - Else if rd_req: pulse rd_ack, go to RWAIT.
  - WCLR: buffer_w_nextburst=1 for one cycle, go to WFILL. nextburst is never asserted in the same cycle as buffer_w_next.
  - WFILL:
    - wr_ack = buffer_w_next = wr_req (combinational). buffer_w_dat/mask pass through wr_dat/wr_mask.
    - Beat counter increments on each accepted beat. After the 4th beat go to WHOLD.
    - Gaps (wr_req low) are allowed; nothing is pushed in gap cycles.
  - WHOLD: wready=1. On wgo go to WDRIVE. wgo outside WHOLD is ignored.
  - WDRIVE: op_write=1 for exactly 4 cycles (counter 0..3), then IDLE. The first op_write cycle is the cycle after wgo is sampled.
  - RWAIT: on rgo go to RDRIVE. rgo outside RWAIT is ignored.
  - RDRIVE: op_read=1 for exactly 4 cycles, then RLAT.
  - RLAT: wait RD_LAT cycles, then go to RCLR.
  - RCLR: buffer_r_nextburst=1 for one cycle, go to RDRAIN.
  - RDRAIN: 4 cycles, buffer_r_next=1 in each.
    - rd_dat <= buffer_r_dat registered each cycle; rd_valid asserts one cycle later, so latency is 1 clk.
    - After 4 beats return to IDLE. rd_valid is low outside the 4 drain-beat slots.
- The host cannot stall reads; rd_valid is not back-pressured.
- busy=1 in every state except IDLE.
- wready is high only in WHOLD.
- Counters: beat counter is 2 bits and wraps 3→0 at the end of a burst. Latency counter is 4 bits.
- Reset mid-burst: immediate return to IDLE with all strobes low. A partially filled write buffer is discarded, because the next write starts with a nextburst pulse.
- op_write and op_read are never high together. At most one burst is in flight.

Optional Feature:
HPDMC_DATABRIDGE_STATS_EN
- Defined:
  - Adds outputs stat_wbursts and stat_rbursts, each WCNT_W bits, reset 0.
  - stat_wbursts increments on the last op_write cycle; stat_rbursts on the last rd_valid beat.
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write burst: reset, wr_req with beats 0x1111..,0x2222..,0x3333..,0x4444.., masks 0x00 → WCLR nextburst pulse; 4 buffer_w_next pulses carrying the same data; wready=1; then wgo → op_write high exactly 4 cycles starting the next cycle; busy drops afterwards.
- Gapped write: wr_req low for 2 cycles between beats 2 and 3 → exactly 4 w_next pulses; wr_ack mirrors wr_req; no nextburst during WFILL.
- Read burst, RD_LAT=4: rd_req → rd_ack pulse; rgo → op_read 4 cycles, 4 idle cycles, r_nextburst, 4 r_next.
  - With the buffer preloaded A,B,C,D: rd_valid ×4 with rd_dat A,B,C,D, each 1 cycle after its pop.
- Simultaneous wr_req and rd_req in IDLE → write serviced first; rd_ack only after the write returns to IDLE.
- Reset asserted in WDRIVE cycle 2 → op_write=0 immediately, busy=0; a subsequent write completes normally with a fresh nextburst.
- With the STATS_EN macro defined: 3 writes and 2 reads → stat_wbursts=3, stat_rbursts=2.

Source files
------------

// File: rtl/hpdmc_databridge.sv
// Host-side burst sequencer between the bus port and the DDR datapath buffers.
// Optional burst statistics are enabled by defining HPDMC_DATABRIDGE_STATS_EN.
module hpdmc_databridge #(
  parameter int RD_LAT = 4,
  parameter int WCNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  output logic        wr_ack,
  input  logic [63:0] wr_dat,
  input  logic [7:0]  wr_mask,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [63:0] rd_dat,
  output logic        rd_valid,
  input  logic        wgo,
  input  logic        rgo,
  output logic        wready,
  output logic        busy,
  output logic        op_write,
  output logic        op_read,
  output logic        buffer_w_next,
  output logic        buffer_w_nextburst,
  output logic [7:0]  buffer_w_mask,
  output logic [63:0] buffer_w_dat,
  output logic        buffer_r_next,
  output logic        buffer_r_nextburst,
  input  logic [63:0] buffer_r_dat
`ifdef HPDMC_DATABRIDGE_STATS_EN
  ,
  output logic [WCNT_W-1:0] stat_wbursts,
  output logic [WCNT_W-1:0] stat_rbursts
`endif
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WCLR   = 4'd1;
  localparam logic [3:0] S_WFILL  = 4'd2;
  localparam logic [3:0] S_WHOLD  = 4'd3;
  localparam logic [3:0] S_WDRIVE = 4'd4;
  localparam logic [3:0] S_RWAIT  = 4'd5;
  localparam logic [3:0] S_RDRIVE = 4'd6;
  localparam logic [3:0] S_RLAT   = 4'd7;
  localparam logic [3:0] S_RCLR   = 4'd8;
  localparam logic [3:0] S_RDRAIN = 4'd9;

  localparam logic [3:0] LAT_END = 4'(RD_LAT - 1);

  if (RD_LAT < 1 || RD_LAT > 15 || WCNT_W < 1) begin : g_param_check
    $error("hpdmc_databridge: RD_LAT must be 1..15 and WCNT_W at least 1");
  end

  logic [3:0] state, state_nxt;
  logic [1:0] cnt;
  logic [3:0] lat;
  logic       beat_step;
  logic       rd_last;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (wr_req) state_nxt = S_WCLR;
                else if (rd_req) state_nxt = S_RWAIT;
      S_WCLR:   state_nxt = S_WFILL;
      S_WFILL:  if (wr_req && cnt == 2'd3) state_nxt = S_WHOLD;
      S_WHOLD:  if (wgo) state_nxt = S_WDRIVE;
      S_WDRIVE: if (cnt == 2'd3) state_nxt = S_IDLE;
      S_RWAIT:  if (rgo) state_nxt = S_RDRIVE;
      S_RDRIVE: if (cnt == 2'd3) state_nxt = S_RLAT;
      S_RLAT:   if (lat == LAT_END) state_nxt = S_RCLR;
      S_RCLR:   state_nxt = S_RDRAIN;
      S_RDRAIN: if (cnt == 2'd3) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // One beat counter serves fill, drive and drain; it only pauses on fill gaps.
  assign beat_step = (state == S_WFILL && wr_req) || state == S_WDRIVE ||
                     state == S_RDRIVE || state == S_RDRAIN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      lat      <= 4'd0;
      rd_dat   <= 64'd0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat_step) cnt <= cnt + 2'd1;
      else if (state != S_WFILL) cnt <= 2'd0;
      if (state == S_RLAT && lat != LAT_END) lat <= lat + 4'd1;
      else lat <= 4'd0;
      if (state == S_RDRAIN) rd_dat <= buffer_r_dat;
      rd_valid <= (state == S_RDRAIN);
      rd_last  <= (state == S_RDRAIN && cnt == 2'd3);
    end
  end

  assign wr_ack             = (state == S_WFILL) && wr_req;
  assign buffer_w_next      = wr_ack;
  assign buffer_w_nextburst = (state == S_WCLR);
  assign buffer_w_dat       = wr_dat;
  assign buffer_w_mask      = wr_mask;
  assign rd_ack             = (state == S_IDLE) && !wr_req && rd_req;
  assign wready             = (state == S_WHOLD);
  assign busy               = (state != S_IDLE);
  assign op_write           = (state == S_WDRIVE);
  assign op_read            = (state == S_RDRIVE);
  assign buffer_r_nextburst = (state == S_RCLR);
  assign buffer_r_next      = (state == S_RDRAIN);

`ifdef HPDMC_DATABRIDGE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wbursts <= '0;
      stat_rbursts <= '0;
    end else begin
      if (state == S_WDRIVE && cnt == 2'd3 && stat_wbursts != '1)
        stat_wbursts <= stat_wbursts + WCNT_W'(1);
      if (rd_last && stat_rbursts != '1)
        stat_rbursts <= stat_rbursts + WCNT_W'(1);
    end
  end
`endif

endmodule
